// File: rtl/spi_adc_responder_pkg.sv
// Shared parameters and state encoding for the SPI ADC responder.
package spi_adc_responder_pkg;

  localparam int unsigned DATA_W        = 12;
  localparam int unsigned NUM_CH        = 8;
  localparam int unsigned ADDR_W        = 3;
  localparam int unsigned FRAME_LEN     = 16;
  localparam int unsigned ADDR_MSB_EDGE = 2;
  localparam int unsigned CNT_W         = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus edge register producing rise/fall strobes.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic pin,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [1:0] warm_q;
  logic       ready;

  // Strobes stay quiet until the chain holds only post-reset samples, so a
  // level already present at reset release is never reported as an edge.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      warm_q <= 2'd0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  assign ready  = (warm_q == 2'd3);
  assign level  = sync_q;
  assign rise_c = ready &  sync_q & ~prev_q;
  assign fall_c = ready & ~sync_q &  prev_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI slave emulating an 8-channel 12-bit serial ADC; lines are oversampled by Clk_i.
module spi_adc_responder
  import spi_adc_responder_pkg::*;
(
  input  logic                     Clk_i,
  input  logic                     Reset_i,
  input  logic                     SCLK_i,
  input  logic                     CS_i,
  input  logic                     MOSI_i,
  input  logic [NUM_CH*DATA_W-1:0] Sample_i,
  output logic                     MISO_o,
  output logic                     MISO_En_o,
  output logic [ADDR_W-1:0]        Addr_o,
  output logic                     Busy_o,
  output logic                     Frame_Done_o,
  output logic                     Frame_Abort_o
);

  localparam logic [CNT_W-1:0] ADDR_FIRST = CNT_W'(ADDR_MSB_EDGE);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_MSB_EDGE + ADDR_W - 1);
  localparam logic [CNT_W-1:0] LAST_RISE  = CNT_W'(FRAME_LEN - 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
    .Clk_i(Clk_i), .Reset_i(Reset_i), .pin(SCLK_i),
    .level(sclk_level), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .Clk_i(Clk_i), .Reset_i(Reset_i), .pin(CS_i),
    .level(cs_level), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .Clk_i(Clk_i), .Reset_i(Reset_i), .pin(MOSI_i),
    .level(mosi_level), .rise_c(mosi_rise), .fall_c(mosi_fall)
  );

  assign unused_sync = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

  logic [DATA_W-1:0] samples [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) samples[i] = Sample_i[i*DATA_W +: DATA_W];
  end

  state_e                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_next_q, addr_next_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   miso_q, miso_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic [FRAME_LEN-1:0]   load_word;

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      addr_next_q <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      addr_next_q <= addr_next_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  // Sample_i is only looked at here, at the instant a frame starts.
  assign load_word = FRAME_LEN'(samples[addr_q]);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    addr_next_d = addr_next_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    en_d        = en_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        en_d   = 1'b0;
        if (cs_fall) begin
          state_d = SHIFT;
          shift_d = load_word;
          cnt_d   = '0;
          en_d    = 1'b1;
          miso_d  = load_word[FRAME_LEN-1];
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          abort_d = 1'b1;
          en_d    = 1'b0;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          if (cnt_q >= ADDR_FIRST && cnt_q <= ADDR_LAST)
            addr_next_d = {addr_next_q[ADDR_W-2:0], mosi_level};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_RISE) begin
            state_d = HOLD;
            addr_d  = addr_next_d;
            done_d  = 1'b1;
            miso_d  = 1'b0;
          end
        end else if (sclk_fall && cnt_q != '0) begin
          // The fall before the first rise only marks the start of the clock train.
          shift_d = shift_q << 1;
          miso_d  = shift_d[FRAME_LEN-1];
        end
      end
      HOLD: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
        en_d    = 1'b0;
      end
    endcase

    busy_d = (state_d == SHIFT);
  end

  assign MISO_o        = miso_q;
  assign MISO_En_o     = en_q;
  assign Addr_o        = addr_q;
  assign Busy_o        = busy_q;
  assign Frame_Done_o  = done_q;
  assign Frame_Abort_o = abort_q;

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

Synthesizable SPI slave that emulates an 8-channel, 12-bit serial ADC in the ADC128S022 style, the device the temperature/LDR sensor top's SPI master talks to. It sits on the far end of the master's SCLK/CS/MOSI/MISO lines. It oversamples those lines with the system clock, decodes the channel address the master shifts in, and shifts out the selected channel's sample. It serves as an on-chip loop-back partner for board bring-up and as a bit-accurate bench model.

## Interface
- DATA_W, 12, sample width
- NUM_CH, 8, channel count (address width ADDR_W = 3)
- FRAME_LEN, 16, SCLK rising edges per frame
- ADDR_MSB_EDGE, 2, zero-based rising-edge index at which ADD2 is sampled; ADD1 and ADD0 follow on the next two edges

Ports:
- Clk_i  in  1  system clock
- Reset_i  in  1  reset, asynchronous, active-low
- SCLK_i  in  1  SPI clock from master, CPOL=1 (idle high), asynchronous to Clk_i
- CS_i  in  1  chip select, active-low, asynchronous
- MOSI_i  in  1  master data (DIN)
- Sample_i  in  NUM_CH*DATA_W  channel samples, channel n at bits [n*DATA_W +: DATA_W]
- MISO_o  out  1  slave data (DOUT)
- MISO_En_o  out  1  output enable for the top-level tristate buffer
- Addr_o  out  3  channel served by the next frame
- Busy_o  out  1  frame in progress
- Frame_Done_o  out  1  one-cycle pulse when a frame completes
- Frame_Abort_o  out  1  one-cycle pulse when CS rises early

## Operation
- SCLK, CS and MOSI each pass through a 2-FF synchronizer and one edge register. The FSM uses only these synchronized versions and the edge strobes.
- States:
  - IDLE: CS high.
  - SHIFT: CS low and rise_cnt < FRAME_LEN.
  - HOLD: full frame done, CS still low.
- IDLE -> SHIFT on CS fall:
  - Load shift_r = {4'b0, Sample_i[Addr_o]}. This is the only point where Sample_i is captured.
  - rise_cnt = 0, MISO_En_o = 1, MISO_o = shift_r[15].
- SHIFT, SCLK rise:
  - If rise_cnt is in ADDR_MSB_EDGE..ADDR_MSB_EDGE+2, shift MOSI into addr_next_r, MSB first.
  - rise_cnt++.
- SHIFT, SCLK fall:
  - If rise_cnt > 0, left-shift shift_r and drive the new MSB on MISO_o.
  - Falls with rise_cnt == 0 are ignored.
- SHIFT -> HOLD on the FRAME_LEN-th rise:
  - Addr_o <= addr_next_r.
  - Frame_Done_o pulses in the same cycle as the transition.
- HOLD:
  - MISO_o = 0.
  - Further SCLK edges are ignored.
- HOLD -> IDLE on CS rise: MISO_En_o = 0.
- SHIFT -> IDLE on CS rise with rise_cnt < FRAME_LEN:
  - Frame_Abort_o pulses.
  - Addr_o is unchanged.
  - MISO_En_o = 0.
- CS fall while not in IDLE cannot occur, since CS is a single level. If CS falls in the same cycle as reset release, the fall is ignored; the next fall starts a frame.
- Busy_o = (state == SHIFT).
- Reset values: state IDLE, MISO_o 0, MISO_En_o 0, Addr_o 0, Busy_o 0, pulses 0, counters 0.
- Reset mid-frame: immediate return to IDLE. No Done or Abort pulse. The master's current frame is lost.

## Timing
- Pin-to-action latency is 3 Clk_i cycles: 2 synchronizer stages plus the edge register. An SCLK fall changes MISO_o on the 3rd Clk_i rising edge after it.
- SCLK high and low phases must each be at least 4 Clk_i periods. The master therefore samples MISO on SCLK rise with at least 1 cycle of margin.
- MOSI must be stable for 3 Clk_i cycles around each SCLK rise.
- The address shifted in during frame k selects the data for frame k+1. The first frame after reset returns channel 0.
- Frame_Done_o and Frame_Abort_o are mutually exclusive and last exactly 1 cycle each.

## Structure
- Shared parameters include file (the sensor design's common parameter header) holds FRAME_LEN, DATA_W, NUM_CH, ADDR_MSB_EDGE and the state encodings IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2.
- One sub-module, spi_sync_edge: a 2-FF synchronizer plus rise/fall strobes, instantiated three times (SCLK, CS, MOSI; rise/fall outputs unused for MOSI).

## Test plan
- Reset, Sample ch0=12'h02B, ch5=12'hABC. Frame 1 with MOSI address 3'b101, SCLK half-period 5 Clk_i -> MISO bits 0000_0000_0010_1011; Frame_Done_o pulses once; Addr_o=5.
- Frame 2 with address 3'b000 -> MISO 0000_1010_1011_1100; Addr_o=0 after the frame.
- CS raised after 7 rises with address 3'b011 -> Frame_Abort_o pulses; Addr_o keeps its old value; MISO_En_o=0 within 3 cycles; the next frame returns the old channel.
- Sample_i ch0 changed from 12'h02B to 12'hFFF mid-frame -> the in-flight frame still returns 12'h02B; the next frame returns 12'hFFF.
- Reset_i asserted after 9 rises -> all outputs take reset values within one Clk_i cycle; no Done or Abort pulse; the following frame serves channel 0.
- 20 SCLK cycles with CS held low -> Done pulses at the 16th rise; MISO_o=0 for rises 17-20; no second pulse.
